// File: rtl/sort4_stream_pkg.sv
// sort4_stream_pkg: shared FSM states and comparator result codes
package sort4_stream_pkg;
    typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2} state_t;
    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_FIRST_GT = 2'b01;
    localparam logic [1:0] CMP_SECOND_GT = 2'b10;
endpackage

// File: rtl/sort4_stream_if.sv
// sort4_stream_if: valid/ready input and output streams of 2-bit values
interface sort4_stream_if;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [1:0] in_data, out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/sort4_stream_cmp.sv
// sort4_stream_cmp: 2-bit unsigned comparator, 01 = first greater, 10 = second greater
module sort4_stream_cmp
    import sort4_stream_pkg::*;
(
    input  logic [1:0] first,
    input  logic [1:0] second,
    output logic [1:0] cmp
);
    assign cmp = first > second ? CMP_FIRST_GT : first < second ? CMP_SECOND_GT : CMP_EQ;
endmodule

// File: rtl/sort4_stream.sv
// sort4_stream: load DEPTH values, bubble-sort in place one compare per cycle, drain ascending
module sort4_stream
    import sort4_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 3,
    parameter int SWP_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    sort4_stream_if.slave    s,
    output logic             busy,
    output logic [SWP_W-1:0] swaps
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] PMAX = IDX_W'(DEPTH - 2);
    state_t state, state_n;
    logic [1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr, rd, j, pass;
    logic swapped_flag, do_swap, pass_end, sort_done;
    logic [1:0] cmp, first, second;
    logic [AW-1:0] wa, ra, ja, jb;
    assign wa = wr[AW-1:0];
    assign ra = rd[AW-1:0];
    assign ja = j[AW-1:0];
    assign jb = ja + 1'b1;
    assign first = mem[ja];
    assign second = mem[jb];
    sort4_stream_cmp u_cmp (.first(first), .second(second), .cmp(cmp));
    assign do_swap = state == SORT && cmp == CMP_FIRST_GT;
    assign pass_end = j == PMAX - pass;
    // early exit counts a swap made on the final compare of the pass
    assign sort_done = pass_end && (!(swapped_flag || do_swap) || pass == PMAX);
    assign s.in_ready = state == LOAD;
    assign busy = state == SORT;
    assign s.out_valid = state == DRAIN;
    assign s.out_data = state == DRAIN ? mem[ra] : 2'b00;
    always_comb begin
        state_n = state;
        case (state)
            LOAD:    state_n = s.in_valid && wr == LAST ? SORT : LOAD;
            SORT:    state_n = sort_done ? DRAIN : SORT;
            DRAIN:   state_n = s.out_ready && rd == LAST ? LOAD : DRAIN;
            default: state_n = LOAD;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD;
            wr <= '0;
            rd <= '0;
            j <= '0;
            pass <= '0;
            swapped_flag <= 1'b0;
            swaps <= '0;
            mem <= '{default: '0};
        end else begin
            state <= state_n;
            case (state)
                LOAD: if (s.in_valid) begin
                    mem[wa] <= s.in_data;
                    wr <= wr == LAST ? '0 : wr + 1'b1;
                    if (wr == LAST) begin
                        j <= '0;
                        pass <= '0;
                        swapped_flag <= 1'b0;
                        swaps <= '0;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        mem[ja] <= second;
                        mem[jb] <= first;
                        swaps <= swaps + 1'b1;
                        swapped_flag <= 1'b1;
                    end
                    if (!pass_end) j <= j + 1'b1;
                    else if (sort_done) rd <= '0;
                    else begin
                        pass <= pass + 1'b1;
                        j <= '0;
                        swapped_flag <= 1'b0;
                    end
                end
                DRAIN: if (s.out_ready) rd <= rd == LAST ? '0 : rd + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
